// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with packet locking, feeding one registered output slot.
// mux8 steers the granted requester's data into the slot.

module mux8 #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            default: y = d7;
        endcase
    end
endmodule

module rr_arb8 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_valid,
    input  logic [7:0]       in_last,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    input  logic [WIDTH-1:0] in_data4,
    input  logic [WIDTH-1:0] in_data5,
    input  logic [WIDTH-1:0] in_data6,
    input  logic [WIDTH-1:0] in_data7,
    output logic [7:0]       in_ready,
    output logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [2:0]       out_src
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [2:0]       lock_idx, lock_idx_nxt;
    logic [2:0]       winner;
    logic             load;
    logic             xfer;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    logic             vld_p0;
    logic [WIDTH-1:0] data_p0;
    logic             last_p0;
    logic [2:0]       src_p0;

    // Scan from ptr upward (mod 8); with no request the pointer itself is reported.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && in_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign sel  = (state == LOCK) ? lock_idx : winner;
    assign load = !vld_p0 || out_ready;

    mux8 #(.WIDTH(WIDTH)) u_mux8 (
        .sel (sel),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .d4  (in_data4),
        .d5  (in_data5),
        .d6  (in_data6),
        .d7  (in_data7),
        .y   (sel_data)
    );

    assign sel_last = in_last[sel];

    // A locked requester keeps its ready even while it pauses mid-packet.
    always_comb begin
        in_ready = '0;
        if (rst_n && load && (state == LOCK || in_valid[sel]))
            in_ready[sel] = 1'b1;
    end

    assign xfer = in_ready[sel] && in_valid[sel];

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        lock_idx_nxt = lock_idx;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (sel_last) begin
                        ptr_nxt = sel + 3'd1;
                    end else begin
                        state_nxt    = LOCK;
                        lock_idx_nxt = sel;
                    end
                end
                default: begin
                    if (sel_last) begin
                        state_nxt = IDLE;
                        ptr_nxt   = lock_idx + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            lock_idx <= 3'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // Stage p0: output slot; data holds its value when drained without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            last_p0 <= 1'b0;
            src_p0  <= 3'd0;
        end else if (xfer) begin
            vld_p0  <= 1'b1;
            data_p0 <= sel_data;
            last_p0 <= sel_last;
            src_p0  <= sel;
        end else if (vld_p0 && out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_last  = last_p0;
    assign out_src   = src_p0;
endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed scenarios plus randomized traffic against a behavioural model.

module tb_rr_arb8;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_valid;
    logic [7:0]  in_last;
    logic [31:0] d [8];
    logic [7:0]  in_ready;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  out_src;

    int checks = 0;
    int errors = 0;

    // behavioural model: rotation pointer, packet owner, output slot contents
    int          m_ptr;
    bit          m_lock;
    int          m_lidx;
    bit          m_ov;
    logic [31:0] m_od;
    bit          m_ol;
    int          m_os;

    always #5 clk = ~clk;

    rr_arb8 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .in_data4  (d[4]),
        .in_data5  (d[5]),
        .in_data6  (d[6]),
        .in_data7  (d[7]),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    function automatic int m_sel();
        if (m_lock) return m_lidx;
        for (int k = 0; k < 8; k++)
            if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        return m_ptr;
    endfunction

    function automatic logic [7:0] m_ready();
        logic [7:0] r;
        int s;
        r = 8'h00;
        s = m_sel();
        if (rst_n && (!m_ov || out_ready) && (m_lock || in_valid[s])) r[s] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_lock = 0; m_lidx = 0;
        m_ov = 0; m_od = 32'h0; m_ol = 0; m_os = 0;
    endtask

    task automatic m_update();
        int s;
        logic [7:0] r;
        s = m_sel();
        r = m_ready();
        if (r[s] && in_valid[s]) begin
            m_ov = 1; m_od = d[s]; m_ol = in_last[s]; m_os = s;
            if (m_lock) begin
                if (in_last[s]) begin
                    m_lock = 0;
                    m_ptr  = (m_lidx + 1) % 8;
                end
            end else if (in_last[s]) begin
                m_ptr = (s + 1) % 8;
            end else begin
                m_lock = 1;
                m_lidx = s;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 8'h00; in_last = 8'h00; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 32'h0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0 || out_src !== 3'd0 || out_last !== 1'b0) begin
            errors++; $display("FAIL reset_slot got data=%h src=%0d last=%0b want 0", out_data, out_src, out_last);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (sel !== 3'd0 || in_ready !== 8'h00) begin
            errors++; $display("FAIL idle_after_reset got sel=%0d rdy=%h want 0/00", sel, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_xfer got %0b want 0", out_valid); end
        // put a beat in the slot, then hit reset in the middle of a cycle
        @(negedge clk);
        in_valid = 8'h01; in_last = 8'h01; d[0] = 32'h55; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            errors++; $display("FAIL pre_reset_beat got v=%0b d=%h want 1/55", out_valid, out_data);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 8'hFF; in_last = 8'hFF;
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %0b want 0", out_valid); end
        checks++;
        if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %h want 00", in_ready); end
        @(negedge clk);
        in_valid = 8'h00; in_last = 8'h00;
        rst_n = 1'b1;
        #1;
        checks++;
        if (sel !== 3'd0 || in_ready !== 8'h00) begin
            errors++; $display("FAIL release_idle got sel=%0d rdy=%h want 0/00", sel, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL release_no_beat got %0b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        in_valid = 8'hFF; in_last = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = 32'hA0 + i;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (in_ready !== 8'(1 << (k % 8))) begin
                errors++; $display("FAIL rr_ready[%0d] got %h want %h", k, in_ready, 8'(1 << (k % 8)));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 3'(k % 8) || out_data !== 32'hA0 + (k % 8)) begin
                errors++; $display("FAIL rr_beat[%0d] got v=%0b src=%0d d=%h want 1/%0d/%h",
                                   k, out_valid, out_src, out_data, k % 8, 32'hA0 + (k % 8));
            end
        end
    endtask

    task automatic test_packet_lock();
        // pointer now sits at 1, so requester 2 wins ahead of 5
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = (b < 3) ? 8'h24 : 8'h20;
            in_last  = (b == 2) ? 8'h24 : 8'h20;
            d[2] = 32'h200 + b; d[5] = 32'h555;
            #1;
            checks++;
            if (in_ready !== ((b < 3) ? 8'h04 : 8'h20)) begin
                errors++; $display("FAIL lock_ready[%0d] got %h want %h", b, in_ready, (b < 3) ? 8'h04 : 8'h20);
            end
            tick();
            checks++;
            if (out_src !== ((b < 3) ? 3'd2 : 3'd5) || out_data !== ((b < 3) ? 32'h200 + b : 32'h555)) begin
                errors++; $display("FAIL lock_beat[%0d] got src=%0d d=%h", b, out_src, out_data);
            end
        end
        @(negedge clk);
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 8'h08; in_last = 8'h08; d[3] = 32'hDEADBEEF; out_ready = 1'b0;
        tick();
        d[3] = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready[%0d] got %h want 00", c, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 3'd3) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%0b d=%h src=%0d want 1/deadbeef/3",
                                   c, out_valid, out_data, out_src);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'h08) begin errors++; $display("FAIL bp_release_ready got %h want 08", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
            errors++; $display("FAIL bp_no_bubble got v=%0b d=%h want 1/12345678", out_valid, out_data);
        end
        @(negedge clk);
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_wrap_skip();
        @(negedge clk);
        in_valid = 8'h20; in_last = 8'hFF; d[5] = 32'h5;
        tick();
        @(negedge clk);
        in_valid = 8'h03; d[0] = 32'hC0; d[1] = 32'hC1;
        #1;
        checks++;
        if (sel !== 3'd0) begin errors++; $display("FAIL wrap_sel0 got %0d want 0", sel); end
        tick();
        checks++;
        if (out_src !== 3'd0 || out_data !== 32'hC0) begin
            errors++; $display("FAIL wrap_beat0 got src=%0d d=%h want 0/c0", out_src, out_data);
        end
        @(negedge clk);
        in_valid = 8'h02;
        #1;
        checks++;
        if (in_ready !== 8'h02) begin errors++; $display("FAIL wrap_ready1 got %h want 02", in_ready); end
        tick();
        checks++;
        if (out_src !== 3'd1) begin errors++; $display("FAIL wrap_beat1 got src=%0d want 1", out_src); end
        @(negedge clk);
        in_valid = 8'h00;
        #1;
        checks++;
        if (sel !== 3'd2) begin errors++; $display("FAIL wrap_ptr got %0d want 2", sel); end
        tick();
    endtask

    task automatic test_lock_gap();
        @(negedge clk);
        in_valid = 8'h10; in_last = 8'h00; d[4] = 32'h400; d[1] = 32'h100;
        tick();
        checks++;
        if (out_src !== 3'd4 || out_data !== 32'h400) begin
            errors++; $display("FAIL gap_first got src=%0d d=%h want 4/400", out_src, out_data);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 8'h02; in_last = 8'h02;
            #1;
            checks++;
            if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL gap_starve[%0d] got %h", c, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_nobeat[%0d] got %0b want 0", c, out_valid); end
        end
        @(negedge clk);
        in_valid = 8'h12; in_last = 8'h12; d[4] = 32'h401;
        #1;
        checks++;
        if (in_ready !== 8'h10) begin errors++; $display("FAIL gap_resume_ready got %h want 10", in_ready); end
        tick();
        checks++;
        if (out_src !== 3'd4 || out_data !== 32'h401 || out_last !== 1'b1) begin
            errors++; $display("FAIL gap_last got src=%0d d=%h l=%0b want 4/401/1", out_src, out_data, out_last);
        end
        @(negedge clk);
        in_valid = 8'h02;
        tick();
        checks++;
        if (out_src !== 3'd1 || out_data !== 32'h100) begin
            errors++; $display("FAIL gap_next got src=%0d d=%h want 1/100", out_src, out_data);
        end
        @(negedge clk);
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] acc;
        acc = 8'hFF;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    in_valid[i] = ($urandom_range(0, 1) == 1);
                    in_last[i]  = ($urandom_range(0, 4) < 2);
                    d[i]        = $urandom;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (in_ready !== m_ready() || sel !== 3'(m_sel())) begin
                errors++; $display("FAIL rand_arb[%0d] got rdy=%h sel=%0d want %h/%0d",
                                   c, in_ready, sel, m_ready(), m_sel());
            end
            acc = m_ready() & in_valid;
            tick();
            checks++;
            if (out_valid !== m_ov || (m_ov && (out_data !== m_od || out_src !== 3'(m_os) || out_last !== m_ol))) begin
                errors++; $display("FAIL rand_out[%0d] got v=%0b d=%h s=%0d l=%0b want %0b/%h/%0d/%0b",
                                   c, out_valid, out_data, out_src, out_last, m_ov, m_od, m_os, m_ol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_wrap_skip();
        test_lock_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- 8-requester round-robin arbiter with packet locking. Produces the 3-bit select that steers an 8:1 mux8 data path, and registers the selected beat into a single output slot.
- Sits directly upstream of the shared 32-bit consumer (bus/writeback port). Merges up to eight valid/ready beat streams into one.
- Grant is held from a packet's first beat through its last beat. It then rotates to the next requester after the winner.

Parameters:
- WIDTH, 32, data width of each requester and of the output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  8  per-requester beat valid.
- in_last  input  8  per-requester last-beat-of-packet flag (sampled with valid).
- in_data0..in_data7  input  WIDTH each  per-requester data.
- in_ready  output  8  per-requester ready; at most one bit high.
- sel  output  3  current grant index; drives the mux8 select internally; exported for debug/trace.
- out_valid  output  1  output slot holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered selected data.
- out_last  output  1  registered last flag of the beat.
- out_src  output  3  registered index of the requester that supplied the beat.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ptr=0, lock_idx=0, out_valid=0, out_data=0, out_last=0, out_src=0. Outputs hold these until the first rising edge after release.
- in_ready is forced 0 while rst_n is low.
- Transfer definitions:
  - In-transfer on requester i: in_valid[i] && in_ready[i].
  - Out-transfer: out_valid && out_ready.
- Slot load enable: load = !out_valid || out_ready. This gives full throughput of one beat/cycle and no bubble when the consumer is always ready.
- Winner (IDLE only, combinational): the first i with in_valid[i]=1, searching ptr, ptr+1, ... ptr+7 mod 8. If none is valid, the winner is ptr (no ready is asserted).
- sel:
  - In IDLE, sel = winner.
  - In LOCK, sel = lock_idx.
- Data steering: data is selected by a mux8 #(WIDTH) instance on sel. in_last is selected by sel the same way.
- in_ready[i] = (i == sel) && load && (state==LOCK || in_valid[i]). All other bits are 0.
- State machine:
  - IDLE, in-transfer with last=0: go to LOCK, lock_idx <= sel.
  - IDLE, in-transfer with last=1: single-beat packet. Stay IDLE, ptr <= sel+1 mod 8.
  - IDLE, no transfer: stay IDLE, ptr unchanged. Arbitration is not sticky; a new winner is recomputed every cycle.
  - LOCK, in-transfer with last=1: go to IDLE, ptr <= lock_idx+1 mod 8.
  - LOCK, otherwise: stay LOCK. Other requesters are starved until the last beat, even if the locked requester drops valid mid-packet.
- Output slot update:
  - On in-transfer: out_valid<=1; out_data/out_last/out_src <= the selected beat. Latency is 1 cycle from in-transfer to visible out_valid.
  - Out-transfer with no in-transfer: out_valid<=0; data registers hold their value.
  - Out-transfer and in-transfer in the same cycle: the slot is replaced (valid stays 1).
- Backpressure: while out_valid && !out_ready, all in_ready=0 and the slot is stable. out_data, out_last and out_src must not change.
- Pointer wrap: the pointer after requester 7 is 0; 3-bit arithmetic wraps naturally.
- Reset mid-packet: returns to IDLE with ptr=0. Any partially transferred packet is abandoned and the consumer sees no further beats of it.
- Requester protocol: a requester must hold in_valid/in_data/in_last stable until accepted. The arbiter does not check this.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, in_ready=8'h00 immediately; after release with in_valid=0, sel=0 and no transfers.
- Round robin, single beats: in_valid=8'hFF, all last=1, out_ready=1 -> out_src sequence 0,1,2,...,7,0 on consecutive cycles, one beat/cycle, out_data = in_dataN (e.g. 32'hA0+N).
- Packet lock: req 2 sends a 3-beat packet (last on beat 3) while req 5 is valid throughout -> out_src = 2,2,2,5. in_ready[5]=0 until req 2's last beat transfers.
- Backpressure: out_ready=0 for 4 cycles after a beat 32'hDEADBEEF from req 3 -> out_valid=1, out_data=32'hDEADBEEF stable, in_ready=0. On out_ready=1 the next beat loads the same cycle with no bubble.
- Wrap and skip: ptr=6, in_valid=8'b0000_0011 -> grant 0 then 1; then ptr=2.
- Lock with gap: req 4 in LOCK drops in_valid for 2 cycles while req 1 is valid -> in_ready[1] stays 0 and no beats are emitted; req 4 resumes and completes, then req 1 is granted.
